// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared FSM states, owner encodings and read-latency bounds for mem_bus_arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;
   localparam int CNT_W = $clog2(RD_LAT_MAX + 1);
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, loader and RAM bus signals; master is the arbiter side, slave the environment side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();
   logic              cpu_req, cpu_we, cpu_done, cpu_busy;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              ldr_req, ldr_we, ldr_done;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic              owner;
   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ram_rdata,
      output cpu_rdata, cpu_done, cpu_busy,
      output ldr_rdata, ldr_done,
      output ram_we, ram_re, ram_addr, ram_wdata, owner
   );
   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ram_rdata,
      input  cpu_rdata, cpu_done, cpu_busy,
      input  ldr_rdata, ldr_done,
      input  ram_we, ram_re, ram_addr, ram_wdata, owner
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port RAM between CPU and UART loader (issue / latency wait / done).
// MEM_ARB_ROUND_ROBIN_EN: ties alternate away from the current owner instead of favouring the loader.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input logic clk,
   input logic reset,
   mem_bus_arbiter_if.master bus
);
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              grant, pick, cap, own, lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata, cpu_rd, ldr_rd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   assign pick = (bus.cpu_req && bus.ldr_req) ? ~own : bus.ldr_req;
`else
   assign pick = bus.ldr_req;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      grant   = 1'b0;
      cap     = 1'b0;
      case (state)
         IDLE:  if (bus.cpu_req || bus.ldr_req) begin
                   grant   = 1'b1;
                   state_n = ISSUE;
                end
         ISSUE: begin
                   state_n = lat_we ? DONE : WAIT;
                   cnt_n   = lat_we ? cnt : CNT_W'(RD_LAT - 1);
                end
         WAIT:  if (cnt == '0) begin
                   cap     = 1'b1;
                   state_n = DONE;
                end else
                   cnt_n = cnt - 1'b1;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         own       <= OWN_CPU;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cpu_rd    <= '0;
         ldr_rd    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (grant) begin
            own       <= pick;
            lat_we    <= pick ? bus.ldr_we    : bus.cpu_we;
            lat_addr  <= pick ? bus.ldr_addr  : bus.cpu_addr;
            lat_wdata <= pick ? bus.ldr_wdata : bus.cpu_wdata;
         end
         // ram_rdata is only looked at here, so X elsewhere never reaches the rdata registers
         if (cap && own == OWN_LDR) ldr_rd <= bus.ram_rdata;
         if (cap && own == OWN_CPU) cpu_rd <= bus.ram_rdata;
      end
   end

   assign bus.ram_we    = (state == ISSUE) && lat_we;
   assign bus.ram_re    = (state == ISSUE) && !lat_we;
   assign bus.ram_addr  = lat_addr;
   assign bus.ram_wdata = lat_wdata;
   assign bus.cpu_done  = (state == DONE) && (own == OWN_CPU);
   assign bus.ldr_done  = (state == DONE) && (own == OWN_LDR);
   assign bus.cpu_busy  = bus.cpu_req && !bus.cpu_done;
   assign bus.cpu_rdata = cpu_rd;
   assign bus.ldr_rdata = ldr_rd;
   assign bus.owner     = own;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port data RAM between the CPU execute path and the UART program loader, so either can access memory without corrupting the other.
- Sequences each access as issue, read-latency wait, then a completion pulse.
- Drives the CPU-side stall line that feeds the control unit's busyFlag, freezing the step counter while a CPU access is pending.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from ram_re to ram_rdata valid; legal range 1..3.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU access request; level, held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; registered.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  stall to the control unit's busyFlag.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_done  (same directions, widths and meanings as the cpu_* ports, for the UART loader).
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- owner  out  1  current or last grantee; 0 = CPU, 1 = loader.

Behaviour:
- Reset values: all outputs 0, state IDLE, latency counter 0, owner 0.
- State machine, IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
  - IDLE: if any request is high, pick a winner, latch its we/addr/wdata, go to ISSUE. If no request, stay in IDLE.
  - Fixed priority: loader beats CPU when both request in the same cycle.
  - ISSUE: one cycle only.
    - Write: ram_we=1 with the latched addr/wdata, then go to DONE.
    - Read: ram_re=1, load counter with RD_LAT-1, go to WAIT.
  - WAIT: decrement the counter; when the counter is 0, capture ram_rdata into the owner's rdata register and go to DONE.
  - DONE: pulse the owner's done for one cycle, then go to IDLE.
- ram_addr and ram_wdata:
  - Driven from the latched values in ISSUE and WAIT.
  - Held at the last value elsewhere.
  - ram_we and ram_re are 0 outside ISSUE.
- Latency, counted from the cycle the request is first seen in IDLE (cycle 0):
  - Write: done at cycle 2.
  - Read: done at cycle 2+RD_LAT.
  - Minimum spacing between back-to-back accesses is 3 cycles (write) or 3+RD_LAT cycles (read).
- cpu_busy = cpu_req && !cpu_done. This is combinational, so the control unit holds its step exactly until the done cycle.
- rdata registers hold their value until the next read by the same requester completes. Writes do not modify rdata.
- Request still high in the cycle after done: treated as a new request.
- Request dropped mid-transaction: the RAM access still completes and done still pulses; the requester ignores it.
- Loser of arbitration: its request stays pending and is served on a later IDLE evaluation.
- Under fixed priority a continuously requesting loader starves the CPU. This is accepted because the loader runs only while cpu_run=0.
- Reset mid-transaction: abort immediately; no done pulse, rdata registers cleared, any in-flight write is dropped.
- ram_rdata is sampled only in the final WAIT cycle; X values at other times must not propagate.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, the requester that is not the current owner wins (alternation). A single requester is always granted immediately. After reset, the first tie goes to the loader (owner reset value 0).
- Undefined: fixed loader priority as specified above.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum: IDLE, ISSUE, WAIT, DONE;
  - owner constants: OWN_CPU=0, OWN_LDR=1;
  - RD_LAT bound constants.
- No sub-module needed; the grant pick is a few lines inline, and the FSM plus datapath fit in one module.

Test Plan:
- Default parameters. CPU writes 0xA5 to addr 0x10 -> ram_we=1 with addr 0x10 / data 0xA5 at cycle 1, cpu_done at cycle 2. Then CPU reads 0x10 -> cpu_rdata=0xA5 with cpu_done at cycle 3; cpu_busy high for cycles 0-2.
- cpu_req and ldr_req rise in the same cycle (loader writes 0x3C to 0x20, CPU reads 0x20) -> loader served first. CPU later reads 0x3C. ldr_done precedes cpu_done by 4 cycles.
- RD_LAT=3, loader reads 0x05 -> exactly one ram_re pulse; ldr_done at cycle 5 with the correct data.
- Reset asserted during WAIT of a CPU read -> no cpu_done, all outputs 0 next cycle. A new request afterwards completes normally.
- MEM_ARB_ROUND_ROBIN_EN defined, both requesting continuously for 6 transactions -> owner alternates LDR, CPU, LDR, ...; undefined -> the CPU is never granted.
- cpu_req dropped in ISSUE of a write to 0x7F -> the write still lands and cpu_done pulses. The next request is accepted from IDLE 1 cycle later.
